// File: rtl/fifo_wptr_full.sv
// Write-side pointer and status controller for the async FIFO.
// Keeps binary/Gray write pointers and derives full, afull, level, overflow.
module fifo_wptr_full #(
  parameter int ADDRBITS     = 4,
  parameter int AFULL_THRESH = 14
) (
  input  logic                w_clk,
  input  logic                reset,
  input  logic                w_en,
  input  logic [ADDRBITS:0]   r_syn,
  input  logic                w_ovf_clr,
  output logic                w_wr,
  output logic [ADDRBITS-1:0] w_addr,
  output logic [ADDRBITS:0]   wgrey,
  output logic                w_full,
  output logic                w_afull,
  output logic [ADDRBITS:0]   w_level,
  output logic                w_ovf
);

  localparam int PW = ADDRBITS + 1;

  // Flipping the two MSBs of the read Gray pointer gives the
  // Gray value the write pointer holds exactly DEPTH entries ahead.
  localparam logic [PW-1:0] TOPMASK = PW'(3) << (ADDRBITS - 1);
  localparam logic [PW-1:0] AFTH    = PW'(AFULL_THRESH);

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wgrey;
  logic [PW-1:0] r_level;
  logic          r_full;
  logic          r_afull;
  logic          r_ovf;

  logic [PW-1:0] w_bin_nx;
  logic [PW-1:0] w_grey_nx;
  logic [PW-1:0] w_rbin;
  logic [PW-1:0] w_level_nx;
  logic          w_full_nx;
  logic          w_afull_nx;

  // Gray-to-binary of the synchronized read pointer.
  always_comb begin
    w_rbin = '0;
    for (int i = 0; i < PW; i++) begin
      w_rbin[i] = ^(r_syn >> i);
    end
  end

  assign w_wr       = w_en & ~r_full;
  assign w_bin_nx   = r_wbin + PW'(w_wr);
  assign w_grey_nx  = w_bin_nx ^ (w_bin_nx >> 1);
  assign w_full_nx  = (w_grey_nx == (r_syn ^ TOPMASK));
  assign w_level_nx = w_bin_nx - w_rbin;
  assign w_afull_nx = (w_level_nx >= AFTH);

  // Pointer and status registers; overflow set beats clear.
  always_ff @(posedge w_clk or negedge reset) begin
    if (!reset) begin
      r_wbin  <= '0;
      r_wgrey <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_afull <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_wbin  <= w_bin_nx;
      r_wgrey <= w_grey_nx;
      r_level <= w_level_nx;
      r_full  <= w_full_nx;
      r_afull <= w_afull_nx;
      if (w_en & r_full) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign w_addr  = r_wbin[ADDRBITS-1:0];
  assign wgrey   = r_wgrey;
  assign w_full  = r_full;
  assign w_afull = r_afull;
  assign w_level = r_level;
  assign w_ovf   = r_ovf;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full: scenario tasks plus randomized traffic,
// checked against a write/read counting model.
module tb_fifo_wptr_full;

  localparam int DEPTH = 16;
  localparam int TH    = 14;

  logic       w_clk = 1'b0;
  logic       reset = 1'b1;
  logic       w_en = 1'b0;
  logic [4:0] r_syn = '0;
  logic       w_ovf_clr = 1'b0;
  logic       w_wr;
  logic [3:0] w_addr;
  logic [4:0] wgrey;
  logic       w_full;
  logic       w_afull;
  logic [4:0] w_level;
  logic       w_ovf;

  fifo_wptr_full #(
    .ADDRBITS(4),
    .AFULL_THRESH(TH)
  ) dut (
    .w_clk(w_clk),
    .reset(reset),
    .w_en(w_en),
    .r_syn(r_syn),
    .w_ovf_clr(w_ovf_clr),
    .w_wr(w_wr),
    .w_addr(w_addr),
    .wgrey(wgrey),
    .w_full(w_full),
    .w_afull(w_afull),
    .w_level(w_level),
    .w_ovf(w_ovf)
  );

  always #5 w_clk = ~w_clk;

  // model: total writes accepted, total reads seen via r_syn
  int m_w, m_r, m_level;
  bit m_full, m_afull, m_ovf;
  int total, pass_cnt;
  logic s_wr, e_wr;
  logic [3:0] s_addr;

  function automatic logic [4:0] gray5(input int n);
    logic [4:0] b;
    b = n[4:0];
    return b ^ (b >> 1);
  endfunction

  function automatic logic [17:0] model_vec();
    logic [4:0] lv;
    logic [3:0] av;
    lv = m_level[4:0];
    av = m_w[3:0];
    return {m_full, m_afull, m_ovf, lv, gray5(m_w), av};
  endfunction

  function automatic logic [17:0] dut_vec();
    return {w_full, w_afull, w_ovf, w_level, wgrey, w_addr};
  endfunction

  task automatic model_reset();
    m_w = 0; m_r = 0; m_level = 0;
    m_full = 0; m_afull = 0; m_ovf = 0;
  endtask

  task automatic do_reset();
    w_en = 0; w_ovf_clr = 0; r_syn = '0;
    reset = 0;
    repeat (2) @(posedge w_clk);
    #1;
    reset = 1;
    model_reset();
  endtask

  // drive one cycle; rc = total entries the reader has consumed
  task automatic step(input bit en, input int rc, input bit clr);
    w_en = en; r_syn = gray5(rc); w_ovf_clr = clr;
    #1;
    s_wr = w_wr; s_addr = w_addr;
    e_wr = en && !m_full;
    @(posedge w_clk);
    if (en && m_full) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (e_wr) m_w++;
    m_r = rc;
    m_level = m_w - m_r;
    m_full = (m_level == DEPTH);
    m_afull = (m_level >= TH);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] g1;
    g1 = 5'b00001;
    #1 reset = 0;
    for (int i = 0; i < 6; i++) begin
      w_en = 1'($urandom); r_syn = 5'($urandom);
      #4;
      total++;
      if (dut_vec() !== 18'd0)
        $display("FAIL reset_regs: got %h exp 0", dut_vec());
      else pass_cnt++;
      total++;
      if (w_wr !== w_en)
        $display("FAIL reset_wr: got %b exp %b", w_wr, w_en);
      else pass_cnt++;
    end
    w_en = 0; r_syn = '0;
    @(posedge w_clk); #1;
    reset = 1;
    model_reset();
    step(1, 0, 0);
    total++;
    if (w_addr !== 4'd1 || wgrey !== g1 || w_level !== 5'd1)
      $display("FAIL reset_first_wr: got a=%h g=%b l=%0d exp a=1 g=00001 l=1",
               w_addr, wgrey, w_level);
    else pass_cnt++;
  endtask

  task automatic test_fill();
    logic [4:0] gf;
    gf = 5'b11000;
    do_reset();
    for (int k = 1; k <= 18; k++) begin
      step(1, 0, 0);
      total++;
      if (dut_vec() !== model_vec())
        $display("FAIL fill_state[%0d]: got %h exp %h", k, dut_vec(), model_vec());
      else pass_cnt++;
      total++;
      if (w_afull !== (k >= 14) || w_full !== (k >= 16))
        $display("FAIL fill_flags[%0d]: got af=%b f=%b exp af=%b f=%b",
                 k, w_afull, w_full, k >= 14, k >= 16);
      else pass_cnt++;
    end
    total++;
    if (wgrey !== gf || w_level !== 5'd16 || w_addr !== 4'd0 ||
        w_ovf !== 1'b1 || s_wr !== 1'b0)
      $display("FAIL fill_end: got g=%b l=%0d a=%0d ovf=%b wr=%b exp g=11000 l=16 a=0 ovf=1 wr=0",
               wgrey, w_level, w_addr, w_ovf, s_wr);
    else pass_cnt++;
  endtask

  task automatic test_drain_release();
    step(0, 1, 0);
    total++;
    if (w_full !== 1'b0 || w_level !== 5'd15 || w_ovf !== 1'b1)
      $display("FAIL drain_release: got f=%b l=%0d ovf=%b exp f=0 l=15 ovf=1",
               w_full, w_level, w_ovf);
    else pass_cnt++;
    step(1, 1, 0);
    total++;
    if (s_wr !== 1'b1 || w_full !== 1'b1 || w_level !== 5'd16)
      $display("FAIL drain_refill: got wr=%b f=%b l=%0d exp wr=1 f=1 l=16",
               s_wr, w_full, w_level);
    else pass_cnt++;
    step(0, 1, 1);
    total++;
    if (w_ovf !== 1'b0 || dut_vec() !== model_vec())
      $display("FAIL drain_ovf_clr: got %h exp %h", dut_vec(), model_vec());
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    int hist[$];
    int rc;
    logic [4:0] prev;
    do_reset();
    prev = wgrey;
    for (int k = 0; k < 40; k++) begin
      hist.push_back(m_w);
      rc = (hist.size() >= 3) ? hist[hist.size()-3] : 0;
      step(1, rc, 0);
      total++;
      if ($countones(wgrey ^ prev) != 1 || w_full !== 1'b0)
        $display("FAIL wrap_gray[%0d]: got g=%b prev=%b f=%b exp one bit change f=0",
                 k, wgrey, prev, w_full);
      else pass_cnt++;
      total++;
      if (dut_vec() !== model_vec())
        $display("FAIL wrap_state[%0d]: got %h exp %h", k, dut_vec(), model_vec());
      else pass_cnt++;
      if (k == 31) begin
        total++;
        if (wgrey !== 5'd0 || w_addr !== 4'd0)
          $display("FAIL wrap_32: got g=%b a=%0d exp g=00000 a=0", wgrey, w_addr);
        else pass_cnt++;
      end
      prev = wgrey;
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    repeat (15) step(1, 0, 0);
    step(1, 1, 0);
    total++;
    if (s_wr !== 1'b1 || w_level !== 5'd15 || w_full !== 1'b0)
      $display("FAIL simul_wr_rd: got wr=%b l=%0d f=%b exp wr=1 l=15 f=0",
               s_wr, w_level, w_full);
    else pass_cnt++;
    step(1, 1, 0);
    total++;
    if (w_full !== 1'b1 || w_ovf !== 1'b0)
      $display("FAIL simul_full: got f=%b ovf=%b exp f=1 ovf=0", w_full, w_ovf);
    else pass_cnt++;
    step(1, 1, 1);
    total++;
    if (w_ovf !== 1'b1 || s_wr !== 1'b0)
      $display("FAIL simul_set_wins: got ovf=%b wr=%b exp ovf=1 wr=0", w_ovf, s_wr);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (9) step(1, 0, 0);
    total++;
    if (w_level !== 5'd9)
      $display("FAIL areset_pre: got l=%0d exp 9", w_level);
    else pass_cnt++;
    #3;
    reset = 0;
    #1;
    total++;
    if (dut_vec() !== 18'd0 || w_wr !== 1'b1)
      $display("FAIL areset_clear: got %h wr=%b exp 0 wr=1", dut_vec(), w_wr);
    else pass_cnt++;
    #2;
    reset = 1;
    model_reset();
    step(1, 0, 0);
    total++;
    if (s_addr !== 4'd0 || s_wr !== 1'b1 || w_addr !== 4'd1)
      $display("FAIL areset_first: got a=%0d wr=%b next=%0d exp a=0 wr=1 next=1",
               s_addr, s_wr, w_addr);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int rc;
    bit en, clr;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      en = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0);
      rc = m_r + int'($urandom_range(0, 2));
      if (rc > m_w) rc = m_w;
      step(en, rc, clr);
      total++;
      if (s_wr !== e_wr)
        $display("FAIL rand_wr[%0d]: got %b exp %b", k, s_wr, e_wr);
      else pass_cnt++;
      total++;
      if (dut_vec() !== model_vec())
        $display("FAIL rand_state[%0d]: got %h exp %h", k, dut_vec(), model_vec());
      else pass_cnt++;
    end
  endtask

  initial begin
    total = 0;
    pass_cnt = 0;
    model_reset();
    test_reset();
    test_fill();
    test_drain_release();
    test_wrap();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
